knight_jump_anim_ctrl: RTL and testbench
========================================

// Module: knight_jump_anim_ctrl
// PURPOSE
//  Sequencer for the knight-jump sprite ROM/palette datapath. Steps through a
//  vertically stacked sprite sheet (NUM_FRAMES frames of SPR_W x SPR_H) on
//  video-frame boundaries. Places the sprite at a latched screen position and
//  drives the ROM read address plus an in-window flag per pixel.
//  Sits between the VGA controller (DrawX/DrawY, frame_start) and the sprite ROM.
// PARAMETERS
//  SPR_W      30  sprite width in pixels
//  SPR_H      40  sprite height in pixels
//  NUM_FRAMES 8   animation frames in the ROM, frame k based at k*SPR_W*SPR_H
//  FRAME_HOLD 4   video frames each animation frame is shown (>=1)
//  ADDR_W     14  ROM address width; must hold NUM_FRAMES*SPR_W*SPR_H-1
// PORTS
//  vga_clk      in   1       pixel clock; all state on posedge
//  reset_n      in   1       asynchronous, active-low reset
//  frame_start  in   1       1-cycle pulse at start of vertical blank
//  jump_req     in   1       request to play the jump animation (sampled per cycle)
//  loop_en      in   1       1: wrap to frame 0 and keep playing; 0: one-shot
//  DrawX        in   10      current pixel x
//  DrawY        in   10      current pixel y
//  sprite_x     in   10      requested sprite top-left x
//  sprite_y     in   10      requested sprite top-left y
//  rom_address  out  ADDR_W  sprite ROM read address, registered
//  sprite_hit   out  1       pixel inside sprite window; aligned with rom_address
//  frame_idx    out  3       current animation frame ($clog2(NUM_FRAMES))
//  busy         out  1       1 while state != IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, frame_idx=0, hold_cnt=0, frame_base=0,
//   latched x0/y0=0, rom_address=0, sprite_hit=0, busy=0.
//  FSM states: IDLE, ARMED, PLAY.
//   - IDLE + jump_req & !frame_start -> ARMED.
//   - IDLE + jump_req & frame_start -> PLAY, with hold_cnt=0 and frame_idx=0.
//   - ARMED + frame_start -> PLAY, with hold_cnt=0 and frame_idx=0.
//   - PLAY + frame_start: if hold_cnt==FRAME_HOLD-1, set hold_cnt=0 and advance.
//     Otherwise hold_cnt++.
//   - Advance: if frame_idx<NUM_FRAMES-1, then frame_idx++ and
//     frame_base+=SPR_W*SPR_H.
//     At the last frame: frame_idx=0 and frame_base=0; then stay in PLAY if
//     loop_en, else -> IDLE.
//   - jump_req in ARMED or PLAY is ignored (no queuing).
//   - loop_en is sampled only at the last-frame advance.
//  frame_base is kept as a running register (no multiply by frame_idx).
//  Position shadowing: sprite_x/sprite_y are captured into x0/y0 on every
//   frame_start, in any state. Changes mid-frame never move the sprite in
//   the visible frame.
//  Address path (1 vga_clk latency; ROM samples on the following negedge):
//   - in_win = (DrawX>=x0) && (DrawX<x0+SPR_W) && (DrawY>=y0) && (DrawY<y0+SPR_H).
//   - Compares are 11-bit, so x0+SPR_W>1023 does not wrap.
//   - in_win: rom_address <= frame_base + (DrawY-y0)*SPR_W + (DrawX-x0).
//   - !in_win: rom_address <= 0.
//   - sprite_hit <= in_win.
//   - frame_base and frame_idx used for a pixel are the values in effect on
//     that cycle. Updates happen only on frame_start, inside blanking, so
//     there is no tearing.
//  IDLE still drives frame 0 at x0/y0 (standing pose). busy=(state!=IDLE).
//  Reset mid-animation: immediate return to IDLE and frame 0; outputs forced
//   to reset values asynchronously.
// TESTING
//  1. Reset -> rom_address=0, sprite_hit=0, frame_idx=0, busy=0.
//     Release, no jump_req, 10 frame_starts -> frame_idx stays 0.
//  2. x0=100, y0=50 latched, IDLE, DrawX=105, DrawY=53
//     -> next cycle rom_address=95, sprite_hit=1.
//     DrawX=130 -> rom_address=0, sprite_hit=0.
//  3. jump_req pulse, then frame_start (entry) -> busy=1, frame_idx=0.
//     Each 4th further frame_start increments frame_idx.
//     After 32 further frame_starts with loop_en=0 -> IDLE, frame_idx=0, busy=0.
//  4. Same as 3 with loop_en=1: 32nd frame_start -> frame_idx=0, busy=1.
//     Then frame_idx=2, x0=100, y0=50, DrawX=105, DrawY=53 -> rom_address=2495.
//  5. Change sprite_x mid-frame from 100 to 200 -> hits still at x 100..129
//     until the next frame_start, then 200..229.
//     jump_req and frame_start in the same cycle from IDLE -> PLAY directly.
//  6. reset_n low during PLAY at frame_idx=5 -> immediate IDLE, all outputs 0.
//     Edge case: x0=1010 -> DrawX 1010..1023 hit, no wrap to x=0..15.

Source files
------------

// File: rtl/knight_jump_anim_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : knight_jump_anim_ctrl_if
// Brief    : Video-timing / sprite-ROM bundle for the knight-jump sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface knight_jump_anim_ctrl_if #(
    parameter int ADDR_W = 14,
    parameter int FIDX_W = 3
);
    logic              frame_start;
    logic              jump_req;
    logic              loop_en;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        sprite_x;
    logic [9:0]        sprite_y;
    logic [ADDR_W-1:0] rom_address;
    logic              sprite_hit;
    logic [FIDX_W-1:0] frame_idx;
    logic              busy;

    modport master (
        output frame_start, jump_req, loop_en, DrawX, DrawY, sprite_x, sprite_y,
        input  rom_address, sprite_hit, frame_idx, busy
    );

    modport slave (
        input  frame_start, jump_req, loop_en, DrawX, DrawY, sprite_x, sprite_y,
        output rom_address, sprite_hit, frame_idx, busy
    );
endinterface
`default_nettype wire

// File: rtl/knight_jump_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : knight_jump_anim_ctrl
// Brief    : Steps a stacked sprite sheet on frame_start and drives the ROM
//            address plus in-window flag for the current pixel.
// Revision : 1.0 - initial release
// ============================================================================
module knight_jump_anim_ctrl #(
    parameter int SPR_W      = 30,
    parameter int SPR_H      = 40,
    parameter int NUM_FRAMES = 8,
    parameter int FRAME_HOLD = 4,
    parameter int ADDR_W     = 14
) (
    input  wire                      vga_clk,
    input  wire                      reset_n,
    knight_jump_anim_ctrl_if.slave   bus
);
    localparam int FIDX_W   = $clog2(NUM_FRAMES);
    localparam int c_HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ARMED = 2'd1;
    localparam logic [1:0] c_PLAY  = 2'd2;

    localparam logic [ADDR_W-1:0]   c_FRAME_SZ  = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0]   c_SPR_W_A   = ADDR_W'(SPR_W);
    localparam logic [10:0]         c_SPR_W_11  = 11'(SPR_W);
    localparam logic [10:0]         c_SPR_H_11  = 11'(SPR_H);
    localparam logic [FIDX_W-1:0]   c_LAST_IDX  = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [c_HOLD_W-1:0] c_LAST_HOLD = c_HOLD_W'(FRAME_HOLD - 1);

    logic [1:0]          r_state;
    logic [FIDX_W-1:0]   r_frame_idx;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [ADDR_W-1:0]   r_frame_base;
    logic [9:0]          r_x0;
    logic [9:0]          r_y0;
    logic [ADDR_W-1:0]   r_rom_address;
    logic                r_sprite_hit;

    // Window compares are widened to 11 bits so a sprite near x/y=1023 never wraps to 0
    logic [10:0]       w_x, w_y, w_x0, w_y0;
    logic              w_in_win;
    logic [9:0]        w_dx, w_dy;
    logic [ADDR_W-1:0] w_addr;

    assign w_x      = {1'b0, bus.DrawX};
    assign w_y      = {1'b0, bus.DrawY};
    assign w_x0     = {1'b0, r_x0};
    assign w_y0     = {1'b0, r_y0};
    assign w_in_win = (w_x >= w_x0) && (w_x < w_x0 + c_SPR_W_11) &&
                      (w_y >= w_y0) && (w_y < w_y0 + c_SPR_H_11);
    assign w_dx     = bus.DrawX - r_x0;
    assign w_dy     = bus.DrawY - r_y0;
    assign w_addr   = r_frame_base + ADDR_W'(w_dy) * c_SPR_W_A + ADDR_W'(w_dx);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_IDLE;
            r_frame_idx   <= '0;
            r_hold_cnt    <= '0;
            r_frame_base  <= '0;
            r_x0          <= '0;
            r_y0          <= '0;
            r_rom_address <= '0;
            r_sprite_hit  <= 1'b0;
        end else begin
            r_rom_address <= w_in_win ? w_addr : '0;
            r_sprite_hit  <= w_in_win;

            // Position is shadowed during blanking so the visible frame never shifts
            if (bus.frame_start) begin
                r_x0 <= bus.sprite_x;
                r_y0 <= bus.sprite_y;
            end

            case (r_state)
                c_IDLE: begin
                    if (bus.jump_req) begin
                        if (bus.frame_start) begin
                            r_state      <= c_PLAY;
                            r_hold_cnt   <= '0;
                            r_frame_idx  <= '0;
                            r_frame_base <= '0;
                        end else begin
                            r_state <= c_ARMED;
                        end
                    end
                end
                c_ARMED: begin
                    if (bus.frame_start) begin
                        r_state      <= c_PLAY;
                        r_hold_cnt   <= '0;
                        r_frame_idx  <= '0;
                        r_frame_base <= '0;
                    end
                end
                c_PLAY: begin
                    if (bus.frame_start) begin
                        if (r_hold_cnt == c_LAST_HOLD) begin
                            r_hold_cnt <= '0;
                            if (r_frame_idx != c_LAST_IDX) begin
                                r_frame_idx  <= r_frame_idx + 1'b1;
                                r_frame_base <= r_frame_base + c_FRAME_SZ;
                            end else begin
                                r_frame_idx  <= '0;
                                r_frame_base <= '0;
                                if (!bus.loop_en) begin
                                    r_state <= c_IDLE;
                                end
                            end
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_address = r_rom_address;
    assign bus.sprite_hit  = r_sprite_hit;
    assign bus.frame_idx   = r_frame_idx;
    assign bus.busy        = (r_state != c_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_knight_jump_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_knight_jump_anim_ctrl
// Brief    : Directed-vector bench for the knight-jump animation sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_knight_jump_anim_ctrl;
    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    knight_jump_anim_ctrl_if #(.ADDR_W(14), .FIDX_W(3)) bus ();

    knight_jump_anim_ctrl #(
        .SPR_W(30), .SPR_H(40), .NUM_FRAMES(8), .FRAME_HOLD(4), .ADDR_W(14)
    ) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse_fs();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic pixel(input int x, input string tag, input int exp_hit, input int exp_addr);
        bus.DrawX = 10'(x);
        tick();
        check({tag, "_hit"}, 32'(bus.sprite_hit), 32'(exp_hit));
        check({tag, "_addr"}, 32'(bus.rom_address), 32'(exp_addr));
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.jump_req    = 1'b0;
        bus.loop_en     = 1'b0;
        bus.DrawX       = '0;
        bus.DrawY       = '0;
        bus.sprite_x    = 10'd100;
        bus.sprite_y    = 10'd50;

        // 1: reset state, then idle frame_starts
        tick(); tick();
        check("rst_addr", 32'(bus.rom_address), 0);
        check("rst_hit",  32'(bus.sprite_hit), 0);
        check("rst_idx",  32'(bus.frame_idx), 0);
        check("rst_busy", 32'(bus.busy), 0);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) pulse_fs();
        check("idle_idx",  32'(bus.frame_idx), 0);
        check("idle_busy", 32'(bus.busy), 0);

        // 2: standing pose address
        bus.DrawY = 10'd53;
        pixel(105, "idle_in", 1, 95);
        pixel(130, "idle_out", 0, 0);
        bus.DrawX = 10'd105;

        // 3: one-shot jump
        bus.jump_req = 1'b1;
        tick();
        bus.jump_req = 1'b0;
        check("armed_busy", 32'(bus.busy), 1);
        pulse_fs();
        check("entry_busy", 32'(bus.busy), 1);
        check("entry_idx",  32'(bus.frame_idx), 0);
        for (int j = 1; j <= 32; j++) begin
            pulse_fs();
            check($sformatf("os_idx%0d", j),  32'(bus.frame_idx), 32'((j / 4) % 8));
            check($sformatf("os_busy%0d", j), 32'(bus.busy), (j == 32) ? 32'd0 : 32'd1);
        end

        // 4: looping jump, then address in frame 2
        bus.loop_en  = 1'b1;
        bus.jump_req = 1'b1;
        tick();
        bus.jump_req = 1'b0;
        pulse_fs();
        for (int j = 0; j < 32; j++) pulse_fs();
        check("loop_idx",  32'(bus.frame_idx), 0);
        check("loop_busy", 32'(bus.busy), 1);
        for (int j = 0; j < 8; j++) pulse_fs();
        check("loop_idx2", 32'(bus.frame_idx), 2);
        pixel(105, "f2", 1, 2495);

        // 6: asynchronous reset at frame 5
        for (int j = 0; j < 12; j++) pulse_fs();
        check("pre_rst_idx", 32'(bus.frame_idx), 5);
        #2 reset_n = 1'b0;
        #1;
        check("arst_addr", 32'(bus.rom_address), 0);
        check("arst_hit",  32'(bus.sprite_hit), 0);
        check("arst_idx",  32'(bus.frame_idx), 0);
        check("arst_busy", 32'(bus.busy), 0);
        tick();
        reset_n = 1'b1;
        bus.loop_en = 1'b0;
        tick();

        // 5: mid-frame position change is shadowed until frame_start
        pulse_fs();
        bus.sprite_x = 10'd200;
        pixel(100, "old_l", 1, 90);
        pixel(129, "old_r", 1, 119);
        pixel(200, "old_new", 0, 0);
        pulse_fs();
        pixel(100, "new_old", 0, 0);
        pixel(200, "new_l", 1, 90);
        pixel(229, "new_r", 1, 119);

        // 5: jump_req with frame_start from IDLE enters PLAY directly
        bus.jump_req    = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.jump_req    = 1'b0;
        bus.frame_start = 1'b0;
        check("direct_busy", 32'(bus.busy), 1);
        for (int j = 0; j < 4; j++) pulse_fs();
        check("direct_idx", 32'(bus.frame_idx), 1);

        // right-edge window does not wrap
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.sprite_x = 10'd1010;
        pulse_fs();
        pixel(1010, "edge_l", 1, 90);
        pixel(1023, "edge_r", 1, 103);
        pixel(5, "nowrap5", 0, 0);
        pixel(0, "nowrap0", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
